// File: rtl/pwm_pkg.sv
// pwm_pkg: state codes and entry-kind codes shared by pulse_width_meter and its FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

   // Measurement FSM state codes, kept as plain 2-bit constants for legacy tools
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_HIGH = 2'd1;
   localparam state_t ST_LOW  = 2'd2;

   // Entry kind tags carried with each measurement
   localparam logic KIND_HIGH = 1'b0;
   localparam logic KIND_LOW  = 1'b1;

   // Bits per FIFO entry for a given counter width: {kind, sat, width}
   function automatic int entry_bits(input int cnt_w);
      return cnt_w + 2;
   endfunction

endpackage

// File: rtl/pwm_fifo.sv
// pwm_fifo: circular FIFO of measurement entries with a registered head entry.
// Latency: a push into an empty FIFO shows on head_o/vld_o the cycle after the push edge; no bypass.
// Backpressure: pop only when vld_o; a push while full is dropped (ovf_o) unless a same-cycle pop frees a slot.
module pwm_fifo #(
   parameter type entry_t = logic [17:0],
   parameter int  DEPTH   = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  entry_t push_dat_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   vld_o,
   output logic   ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   entry_t        mem_q [DEPTH];
   entry_t        head_q, head_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          empty, full, do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_FULL);
   // A pop on an empty FIFO is a no-op; a full FIFO still accepts a push when a pop frees a slot
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full | do_pop);
   assign ovf_o   = push_i & full & ~do_pop;
   assign vld_o   = ~empty;
   assign head_o  = head_q;

   // Next pointers, occupancy and head register
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
      if (do_push) wr_d = wr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      // Head follows the oldest entry; when only one entry is popped, a same-cycle push lands at rd+1
      if (do_pop) begin
         if (cnt_q > CNT_ONE)  head_d = mem_q[rd_d];
         else if (do_push)     head_d = push_dat_i;
      end else if (empty && do_push) begin
         head_d = push_dat_i;
      end
   end

   // Control and head registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   // Entry storage; contents are only meaningful behind the occupancy count, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat_i;
   end

endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high (and optionally low, PWM_LOW_WIDTH_EN) time between edge strobes, queues results.
// Latency: entry visible on m_* the cycle after the closing edge strobe if the FIFO was empty.
// Backpressure: m_valid/m_ready; a measurement arriving while the FIFO is full is dropped and sets ovf_err.
module pulse_width_meter
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rise_pulse,
   input  logic             fall_pulse,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] m_width,
   output logic             m_kind,
   output logic             m_sat,
   output logic             ovf_err,
   output logic             seq_err,
   input  logic             clr_err
);

`ifdef PWM_LOW_WIDTH_EN
   localparam logic LOW_EN = 1'b1;
`else
   localparam logic LOW_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Entry layout; packages cannot take parameters, so the CNT_W-sized struct lives here
   typedef struct packed {
      logic             kind;
      logic             sat;
      logic [CNT_W-1:0] width;
   } entry_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             arm_q, arm_d;
   logic             ovf_q, seq_q;
   logic             cnt_sat, counting, push, seq_set, fifo_ovf;
   entry_t           meas, head;

   // FSM, counter and measurement formation
   always_comb begin
      // Counter holds cycles elapsed since the opening strobe minus one; the closing cycle adds one
      cnt_sat    = (cnt_q == CNT_MAX);
      cnt_inc    = cnt_sat ? cnt_q : cnt_q + CNT_ONE;
      meas.kind  = KIND_HIGH;
      meas.sat   = cnt_sat;
      meas.width = cnt_sat ? CNT_MAX : cnt_q + CNT_ONE;
      // Low periods are only timed when they started from a real fall, never from IDLE
      counting   = (state_q == ST_HIGH) | (LOW_EN & arm_q & (state_q == ST_LOW));
      state_d    = state_q;
      cnt_d      = counting ? cnt_inc : cnt_q;
      arm_d      = arm_q;
      push       = 1'b0;
      seq_set    = 1'b0;
      if (rise_pulse && fall_pulse) begin
         seq_set = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise_pulse) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
               end else if (fall_pulse) begin
                  state_d = ST_LOW;
                  arm_d   = 1'b0;
               end
            end
            ST_HIGH: begin
               if (fall_pulse) begin
                  push    = 1'b1;
                  state_d = ST_LOW;
                  cnt_d   = '0;
                  arm_d   = 1'b1;
               end else if (rise_pulse) begin
                  seq_set = 1'b1;
                  cnt_d   = '0;
               end
            end
            ST_LOW: begin
               if (rise_pulse) begin
                  if (LOW_EN && arm_q) begin
                     push      = 1'b1;
                     meas.kind = KIND_LOW;
                  end
                  state_d = ST_HIGH;
                  cnt_d   = '0;
               end else if (fall_pulse) begin
                  seq_set = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, counter and sticky error registers; a new error beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         arm_q   <= 1'b0;
         ovf_q   <= 1'b0;
         seq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         arm_q   <= arm_d;
         ovf_q   <= (ovf_q & ~clr_err) | fifo_ovf;
         seq_q   <= (seq_q & ~clr_err) | seq_set;
      end
   end

   pwm_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (meas),
      .pop_i      (m_ready),
      .head_o     (head),
      .vld_o      (m_valid),
      .ovf_o      (fifo_ovf)
   );

   assign m_width = head.width;
   assign m_sat   = head.sat;
   // Without low-width support only high entries exist, so the kind output is forced low
   assign m_kind  = head.kind & LOW_EN;
   assign ovf_err = ovf_q;
   assign seq_err = seq_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed table, hand sequences and randomized run against a timestamp-based model.
// Latency: n/a.
// Backpressure: m_ready driven by stimulus.
module tb_pulse_width_meter;

   localparam int DEPTH = 4;
   localparam int WA    = 16;
   localparam int WB    = 4;
`ifdef PWM_LOW_WIDTH_EN
   localparam bit LOW_EN = 1'b1;
`else
   localparam bit LOW_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, rise, fall, ready, clr;
   logic a_vld, a_kind, a_sat, a_ovf, a_seq;
   logic b_vld, b_kind, b_sat, b_ovf, b_seq;
   logic [WA-1:0] a_w;
   logic [WB-1:0] b_w;

   always #5 clk = ~clk;

   pulse_width_meter #(.CNT_W(WA), .DEPTH(DEPTH)) u_dut_a (
      .clk(clk), .rst(rst), .rise_pulse(rise), .fall_pulse(fall),
      .m_valid(a_vld), .m_ready(ready), .m_width(a_w), .m_kind(a_kind), .m_sat(a_sat),
      .ovf_err(a_ovf), .seq_err(a_seq), .clr_err(clr));

   pulse_width_meter #(.CNT_W(WB), .DEPTH(DEPTH)) u_dut_b (
      .clk(clk), .rst(rst), .rise_pulse(rise), .fall_pulse(fall),
      .m_valid(b_vld), .m_ready(ready), .m_width(b_w), .m_kind(b_kind), .m_sat(b_sat),
      .ovf_err(b_ovf), .seq_err(b_seq), .clr_err(clr));

   // Reference model: timestamps of the opening strobe and a queue of raw (unsaturated) widths
   typedef enum {M_IDLE, M_HIGH, M_LOW} mstate_t;
   typedef struct { bit kind; int w; } ent_t;

   mstate_t mst;
   int      cyc, t_start;
   bit      armed, e_ovf, e_seq;
   ent_t    q[$];
   int      n_chk, n_pass;
   int      exp_order[4] = '{2, 3, 4, 6};

   typedef struct { int gap; bit rst; bit r; bit f; bit rdy; bit c; bit e_vld; int e_w; bit e_seq; } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
   endtask

   function automatic longint pack(input ent_t e, input int bits);
      int  mx;
      bit  sat;
      mx  = (1 << bits) - 1;
      sat = (e.w > mx);
      return {e.kind, sat, 32'(sat ? mx : e.w)};
   endfunction

   task automatic model_step(input bit r, input bit f, input bit rdy, input bit c);
      bit   pop, have;
      ent_t e;
      cyc++;
      pop  = rdy && (q.size() > 0);
      have = 0;
      e    = '{1'b0, 0};
      if (c) begin e_ovf = 0; e_seq = 0; end
      if (r && f) e_seq = 1;
      else case (mst)
         M_IDLE: if (r) begin mst = M_HIGH; t_start = cyc; end
                 else if (f) begin mst = M_LOW; armed = 0; end
         M_HIGH: if (f) begin have = 1; e = '{1'b0, cyc - t_start}; mst = M_LOW; t_start = cyc; armed = 1; end
                 else if (r) begin e_seq = 1; t_start = cyc; end
         M_LOW:  if (r) begin
                    if (LOW_EN && armed) begin have = 1; e = '{1'b1, cyc - t_start}; end
                    mst = M_HIGH; t_start = cyc;
                 end else if (f) e_seq = 1;
         default: mst = M_IDLE;
      endcase
      if (have && q.size() == DEPTH && !pop) begin
         e_ovf = 1;
         have  = 0;
      end
      if (pop) void'(q.pop_front());
      if (have) q.push_back(e);
   endtask

   task automatic model_check();
      chk("a_valid", a_vld, q.size() > 0);
      chk("b_valid", b_vld, q.size() > 0);
      if (q.size() > 0) begin
         chk("a_head", {a_kind, a_sat, 32'(a_w)}, pack(q[0], WA));
         chk("b_head", {b_kind, b_sat, 32'(b_w)}, pack(q[0], WB));
      end
      chk("a_errs", {a_ovf, a_seq}, {e_ovf, e_seq});
      chk("b_errs", {b_ovf, b_seq}, {e_ovf, e_seq});
   endtask

   // One clock cycle: inputs applied at the falling edge, outputs compared at the next falling edge
   task automatic tick(input bit r, input bit f, input bit rdy, input bit c);
      rise = r; fall = f; ready = rdy; clr = c;
      model_step(r, f, rdy, c);
      @(posedge clk);
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset();
      rst = 1; rise = 0; fall = 0; ready = 0; clr = 0;
      #1;
      chk("rst_a_outs", {a_vld, a_kind, a_sat, a_ovf, a_seq, a_w}, 0);
      chk("rst_b_outs", {b_vld, b_kind, b_sat, b_ovf, b_seq, b_w}, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      mst = M_IDLE; q.delete(); e_ovf = 0; e_seq = 0; armed = 0;
   endtask

   initial begin
      rst = 1; rise = 0; fall = 0; ready = 0; clr = 0;
      n_chk = 0; n_pass = 0; cyc = 0; t_start = 0;
      mst = M_IDLE; armed = 0; e_ovf = 0; e_seq = 0;

      //          gap rst  r f rdy c  vld w seq
      tbl[0]  = '{9,  1,   1,0,0, 0,  0,  0,0};
      tbl[1]  = '{4,  0,   0,1,0, 0,  1,  5,0};
      tbl[2]  = '{0,  0,   0,0,1, 0,  0,  0,0};
      tbl[3]  = '{2,  1,   1,0,0, 0,  0,  0,0};
      tbl[4]  = '{0,  0,   0,1,1, 0,  1,  1,0};
      tbl[5]  = '{0,  0,   0,0,1, 0,  0,  0,0};
      tbl[6]  = '{2,  1,   1,0,0, 0,  0,  0,0};
      tbl[7]  = '{5,  0,   1,0,0, 0,  0,  0,1};
      tbl[8]  = '{2,  0,   0,1,0, 0,  1,  3,1};
      tbl[9]  = '{0,  0,   0,0,1, 0,  0,  0,1};
      tbl[10] = '{0,  0,   0,0,0, 1,  0,  0,0};
      tbl[11] = '{0,  0,   1,1,0, 0,  0,  0,1};
      tbl[12] = '{3,  0,   0,0,0, 0,  0,  0,1};
      tbl[13] = '{0,  0,   0,0,0, 1,  0,  0,0};
      tbl[14] = '{0,  0,   1,1,0, 1,  0,  0,1};

      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst) do_reset();
         repeat (tbl[i].gap) tick(0, 0, 0, 0);
         tick(tbl[i].r, tbl[i].f, tbl[i].rdy, tbl[i].c);
         chk("tbl_valid", a_vld, tbl[i].e_vld);
         if (tbl[i].e_vld) chk("tbl_head", {a_kind, a_sat, 32'(a_w)}, {2'b00, 32'(tbl[i].e_w)});
         chk("tbl_seq", a_seq, tbl[i].e_seq);
      end

      // Overflow: widths 1..5 with no consumer, then a push coinciding with a pop on a full FIFO
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         tick(1, 0, 0, 0);
         repeat (k - 1) tick(0, 0, 0, 0);
         tick(0, 1, 0, 0);
         tick(0, 0, 0, 0);
      end
      chk("ovf_set", a_ovf, 1);
      chk("ovf_valid", a_vld, 1);
      tick(0, 0, 0, 1);
`ifndef PWM_LOW_WIDTH_EN
      chk("ovf_clr", a_ovf, 0);
      chk("ovf_head", a_w, 1);
`endif
      tick(1, 0, 0, 0);
      repeat (5) tick(0, 0, 0, 0);
      tick(0, 1, 1, 0);
`ifndef PWM_LOW_WIDTH_EN
      chk("full_pushpop_ovf", a_ovf, 0);
      for (int i = 0; i < 4; i++) begin
         chk("order", a_w, exp_order[i]);
         tick(0, 0, 1, 0);
      end
      chk("drained", a_vld, 0);
`endif

      // Saturation: a 20-cycle high period on both counter widths
      do_reset();
      tick(1, 0, 0, 0);
      repeat (19) tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      chk("sat_a", {a_sat, a_w}, 17'h00014);
      chk("sat_b", {b_sat, b_w}, 5'h1F);

`ifdef PWM_LOW_WIDTH_EN
      // High then low width: rise@10, fall@14, rise@21
      do_reset();
      repeat (9) tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      repeat (6) tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("low_first", {a_kind, a_w}, {1'b0, 16'd4});
      tick(0, 0, 1, 0);
      chk("low_second", {a_kind, a_w}, {1'b1, 16'd7});
`endif

      // Reset mid-HIGH with a queued entry: everything discarded, the orphan fall yields nothing
      do_reset();
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      repeat (5) tick(0, 0, 0, 0);
      chk("pre_rst_valid", a_vld, 1);
      do_reset();
      tick(0, 1, 0, 0);
      chk("rst_mid_none", a_vld, 0);
      repeat (3) tick(0, 0, 0, 0);
      chk("rst_mid_none_later", a_vld, 0);

      // Randomized strobes, consumer duty and clears, alternating light and heavy backpressure
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         bit r, f, rdy, c;
         r   = ($urandom_range(0, 11) == 0);
         f   = ($urandom_range(0, 11) == 0);
         rdy = (((i / 400) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         c   = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
         tick(r, f, rdy, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Consumes the single-cycle rise/fall pulses from the edge-detector stage.
- Measures the high time of the input in clk cycles: from each rise pulse to the next fall pulse.
- Queues each measurement in a small FIFO and presents it on a valid/ready output to the downstream reporter/CSR logic.
- Flags sequencing faults and FIFO overflow with sticky error bits.

Parameters:
- CNT_W, 16: width counter width in bits. Maximum measurable width is 2^CNT_W-1.
- DEPTH, 4: FIFO entries. Must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rise_pulse  in  1  one-cycle rising-edge strobe from the edge detector
- fall_pulse  in  1  one-cycle falling-edge strobe from the edge detector
- m_valid  out  1  FIFO head entry is valid
- m_ready  in  1  consumer accepts the head entry
- m_width  out  CNT_W  measured width of the head entry
- m_kind  out  1  0 = high-width entry, 1 = low-width entry
- m_sat  out  1  head entry width saturated
- ovf_err  out  1  sticky: a measurement was dropped because the FIFO was full
- seq_err  out  1  sticky: illegal pulse sequence detected
- clr_err  in  1  synchronous clear of both sticky error bits

Behaviour:
- Clock and reset: one clock domain. Async active-high rst clears everything.
  - After reset: FSM=IDLE, counter=0, FIFO empty.
  - m_valid=0, m_width=0, m_kind=0, m_sat=0, ovf_err=0, seq_err=0.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: rise_pulse -> HIGH, counter=0. fall_pulse -> LOW, no entry written (first fall after reset has no start reference).
  - HIGH: the counter increments every cycle. fall_pulse -> push {kind=0, width, sat}, go to LOW.
  - LOW: rise_pulse -> HIGH, counter=0.
- Width rule: rise in cycle r and fall in cycle f give width = f - r.
  - Minimum legal width is 1.
  - Counter saturates at 2^CNT_W-1. In that case the entry carries sat=1 and width=all-ones.
- Illegal sequences set seq_err. Each case below is handled as stated:
  - rise_pulse in HIGH: restart counter at 0, no push.
  - fall_pulse in LOW: ignored.
  - rise_pulse and fall_pulse in the same cycle in any state: both ignored, state held.
- FIFO and output:
  - A push at clock edge t makes data visible on m_* at t+1 if the FIFO was empty. There is no bypass.
  - Pop occurs when m_valid & m_ready.
  - m_* hold stable while m_valid=1 and m_ready=0.
  - Push when full without a simultaneous pop: the entry is dropped, ovf_err=1, FIFO contents unchanged.
  - Push when full with a simultaneous pop: both take effect, FIFO stays full, no error.
  - Push and pop on an empty FIFO in the same cycle: the push is kept. The pop is a no-op because m_valid=0.
- Sticky errors:
  - clr_err clears both bits next cycle.
  - If an error condition occurs in the same cycle as clr_err, set wins.
- Reset mid-measurement: the in-flight count and all FIFO contents are discarded.

Optional Feature:
- Macro PWM_LOW_WIDTH_EN.
- Defined:
  - LOW also counts (counter reset on fall_pulse).
  - A rise_pulse in LOW pushes {kind=1, width} before entering HIGH, using the same width and saturation rules.
  - The IDLE->LOW path does not count, so no low entry is produced for the first low period.
- Undefined: no low entries; m_kind is tied to 0.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum {IDLE, HIGH, LOW}
  - kind constants KIND_HIGH=0 and KIND_LOW=1
  - entry struct {kind, sat, width}, sized by CNT_W
- One sub-module, pwm_fifo: a synchronous circular FIFO of entries with full/empty flags, push/pop, and a registered head.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then rise at cycle 10 and fall at cycle 15, m_ready=1 -> one entry: width=5, kind=0, sat=0. m_valid rises the cycle after the fall.
- Rise followed by fall 1 cycle later -> width=1. With CNT_W=4 and a 20-cycle high -> width=15, sat=1.
- m_ready=0 with 5 complete high pulses (DEPTH=4) -> first 4 entries retained, 5th dropped, ovf_err=1. Assert clr_err -> ovf_err=0.
- With the FIFO full, apply a push and a pop in the same cycle -> no ovf_err; output order is preserved.
- Rise, rise (6 cycles later), fall (3 cycles after that) -> seq_err=1, entry width=3. Simultaneous rise+fall -> no entry, seq_err=1.
- With PWM_LOW_WIDTH_EN defined: rise@10, fall@14, rise@21 -> entries (kind=0, width=4) then (kind=1, width=7). Assert rst mid-HIGH -> FIFO empty and no entry for that pulse.
